// File: rtl/jtpinpon_inputs_if.sv
// Cabinet input bus for jtpinpon_inputs: raw active-low controls in,
// frame-synchronous conditioned controls out.
interface jtpinpon_inputs_if;
  logic       LVBL;
  logic [1:0] coin_input;
  logic [1:0] start_button;
  logic [5:0] joystick1;
  logic [5:0] joystick2;
  logic       service;
  logic       pause_btn;
  logic [1:0] coin_out;
  logic [1:0] start_out;
  logic [5:0] joy1_out;
  logic [5:0] joy2_out;
  logic       service_out;
  logic       dip_pause;
  logic       frame;

  modport master (
    output LVBL, coin_input, start_button, joystick1, joystick2, service, pause_btn,
    input  coin_out, start_out, joy1_out, joy2_out, service_out, dip_pause, frame
  );

  modport slave (
    input  LVBL, coin_input, start_button, joystick1, joystick2, service, pause_btn,
    output coin_out, start_out, joy1_out, joy2_out, service_out, dip_pause, frame
  );
endinterface

// File: rtl/jtpinpon_inputs.sv
// Frame-synchronous cabinet input conditioner: debounce, coin pulse shaping,
// SOCD joystick cleanup and pause toggle. Define JTPINPON_AUTOFIRE_EN for b1 autofire.
module jtpinpon_inputs #(
  parameter int DEBOUNCE  = 3,
  parameter int COIN_LEN  = 4,
  parameter int COIN_QMAX = 3
) (
  input logic              clk,
  input logic              rst,
  jtpinpon_inputs_if.slave bus
);

  localparam int NB = 18;

  typedef enum logic [1:0] {COIN_IDLE, COIN_ACTIVE, COIN_GAP} coin_state_e;

  logic          lvbl_q, frame_q;
  logic [NB-1:0] raw, raw_q, stable_q, stable_d;
  logic [2:0]    cnt_q [NB];
  logic [2:0]    cnt_d [NB];
  logic [1:0]    coin_press, coin_deq;
  logic          pause_press;
  coin_state_e   state_q [2];
  coin_state_e   state_d [2];
  logic [3:0]    timer_q [2];
  logic [3:0]    timer_d [2];
  logic [1:0]    pend_q [2];
  logic [1:0]    pend_d [2];
  logic [1:0]    coin_q, coin_d;
  logic [1:0]    start_q;
  logic [5:0]    joy1_q, joy2_q, joy1_d, joy2_d;
  logic          svc_q, pause_q;
  logic [1:0]    b1;

  // Bit map: coins[1:0], starts[3:2], joy1[9:4], joy2[15:10], service[16], pause[17]
  assign raw = {bus.pause_btn, bus.service, bus.joystick2, bus.joystick1,
                bus.start_button, bus.coin_input};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvbl_q  <= 1'b0;
      frame_q <= 1'b0;
      raw_q   <= '1;
    end else begin
      lvbl_q  <= bus.LVBL;
      frame_q <= lvbl_q & ~bus.LVBL;
      if (lvbl_q & ~bus.LVBL) raw_q <= raw;
    end
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (frame_q) begin
        if (raw_q[i] == stable_q[i]) begin
          cnt_d[i] = 3'd0;
        end else if (cnt_q[i] == 3'(DEBOUNCE - 1)) begin
          stable_d[i] = ~stable_q[i];
          cnt_d[i]    = 3'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
    coin_press  = stable_q[1:0] & ~stable_d[1:0];
    pause_press = stable_q[17] & ~stable_d[17];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '1;
      for (int i = 0; i < NB; i++) cnt_q[i] <= 3'd0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef JTPINPON_AUTOFIRE_EN
  logic [1:0] af_q [2];
  logic [1:0] af_d [2];

  // Counter restarts at 0 on the press edge so the first two frames fire
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      af_d[p] = af_q[p];
      if (frame_q) begin
        if (stable_q[(p == 0) ? 8 : 14] && !stable_d[(p == 0) ? 8 : 14])
          af_d[p] = 2'd0;
        else if (!stable_d[(p == 0) ? 8 : 14])
          af_d[p] = af_q[p] + 2'd1;
      end
      b1[p] = stable_d[(p == 0) ? 8 : 14] | af_d[p][1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q[0] <= 2'd0;
      af_q[1] <= 2'd0;
    end else begin
      af_q[0] <= af_d[0];
      af_q[1] <= af_d[1];
    end
  end
`else
  assign b1 = {stable_d[14], stable_d[8]};
`endif

  function automatic logic [5:0] socd(input logic [5:0] j);
    logic [5:0] r;
    r = j;
    if (!j[3] && !j[2]) r[3:2] = 2'b11;
    if (!j[1] && !j[0]) r[1:0] = 2'b11;
    return r;
  endfunction

  assign joy1_d = socd({stable_d[9],  b1[0], stable_d[7:4]});
  assign joy2_d = socd({stable_d[15], b1[1], stable_d[13:10]});

  // Registered from next-state so outputs move one clk after the deciding strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 2'b11;
      joy1_q  <= '1;
      joy2_q  <= '1;
      svc_q   <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      start_q <= stable_d[3:2];
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      svc_q   <= stable_d[16];
      if (pause_press) pause_q <= ~pause_q;
    end
  end

  always_comb begin
    coin_deq = 2'b00;
    coin_d   = coin_q;
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      timer_d[s] = timer_q[s];
      pend_d[s]  = pend_q[s];
      if (frame_q) begin
        case (state_q[s])
          COIN_IDLE: begin
            if (pend_q[s] != 2'd0) begin
              coin_deq[s] = 1'b1;
              coin_d[s]   = 1'b0;
              state_d[s]  = COIN_ACTIVE;
              timer_d[s]  = 4'(COIN_LEN);
            end
          end
          COIN_ACTIVE: begin
            if (timer_q[s] == 4'd1) begin
              coin_d[s]  = 1'b1;
              state_d[s] = COIN_GAP;
              timer_d[s] = 4'(COIN_LEN);
            end else begin
              timer_d[s] = timer_q[s] - 4'd1;
            end
          end
          COIN_GAP: begin
            if (timer_q[s] == 4'd1) begin
              state_d[s] = COIN_IDLE;
              timer_d[s] = 4'd0;
            end else begin
              timer_d[s] = timer_q[s] - 4'd1;
            end
          end
          default: begin
            coin_d[s]  = 1'b1;
            state_d[s] = COIN_IDLE;
            timer_d[s] = 4'd0;
          end
        endcase
      end
      // Presses at a full queue are dropped; press plus dequeue cancels out
      if (coin_press[s] && !coin_deq[s] && pend_q[s] != 2'(COIN_QMAX))
        pend_d[s] = pend_q[s] + 2'd1;
      else if (coin_deq[s] && !coin_press[s])
        pend_d[s] = pend_q[s] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_q <= 2'b11;
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= COIN_IDLE;
        timer_q[s] <= 4'd0;
        pend_q[s]  <= 2'd0;
      end
    end else begin
      coin_q <= coin_d;
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        timer_q[s] <= timer_d[s];
        pend_q[s]  <= pend_d[s];
      end
    end
  end

  assign bus.coin_out    = coin_q;
  assign bus.start_out   = start_q;
  assign bus.joy1_out    = joy1_q;
  assign bus.joy2_out    = joy2_q;
  assign bus.service_out = svc_q;
  assign bus.dip_pause   = pause_q;
  assign bus.frame       = frame_q;

endmodule

// File: tb/tb_jtpinpon_inputs.sv
// Scoreboard bench for jtpinpon_inputs: each issued frame pushes its expected
// outputs; a monitor pops and compares after every frame strobe.
module tb_jtpinpon_inputs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtpinpon_inputs_if bus ();

  jtpinpon_inputs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  string      nameQ[$];
  logic [18:0] expQ[$];
  int checks = 0;
  int errors = 0;
  int frameNo = 0;

  logic [1:0] eCoin, eStart;
  logic [5:0] eJoy1, eJoy2;
  logic       eSvc, ePause;

  int starts[11] = '{4, 13, 22, 31, 40, 49, 58, 67, 76, 85, 94};

  function automatic logic [18:0] actualVec();
    return {bus.coin_out, bus.start_out, bus.joy1_out, bus.joy2_out,
            bus.service_out, bus.dip_pause, bus.frame};
  endfunction

  function automatic logic [18:0] expectVec();
    return {eCoin, eStart, eJoy1, eJoy2, eSvc, ePause, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [18:0] act, input logic [18:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic setIdleExpect();
    eCoin = 2'b11; eStart = 2'b11; eJoy1 = '1; eJoy2 = '1; eSvc = 1'b1; ePause = 1'b1;
  endtask

  task automatic releaseInputs();
    bus.coin_input = 2'b11; bus.start_button = 2'b11;
    bus.joystick1 = '1; bus.joystick2 = '1;
    bus.service = 1'b1; bus.pause_btn = 1'b1;
  endtask

  // One frame: inputs already set by caller, expectation queued, then LVBL low pulse
  task automatic applyStimulus(input string name);
    @(negedge clk);
    frameNo++;
    nameQ.push_back($sformatf("%s#%0d", name, frameNo));
    expQ.push_back(expectVec());
    bus.LVBL = 1'b0;
    repeat (4) @(negedge clk);
    bus.LVBL = 1'b1;
    repeat (11) @(negedge clk);
  endtask

  task automatic frames(input int n, input string name);
    for (int k = 0; k < n; k++) applyStimulus(name);
  endtask

  // Monitor: outputs settle one clk after the strobe; frame must be low by then
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.frame === 1'b1) begin
        @(negedge clk);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: got strobe, expected none");
        end else begin
          checkOutput(nameQ.pop_front(), actualVec(), expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.LVBL = 1'b1;
    releaseInputs();
    setIdleExpect();
    repeat (3) @(negedge clk);
    checkOutput("reset_state", actualVec(), expectVec());
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frames(2, "idle");

    $display("[TB] debounce joystick1 right");
    bus.joystick1 = 6'b111110; frames(2, "debounce");
    bus.joystick1 = 6'b111111; frames(1, "debounce");
    bus.joystick1 = 6'b111110; frames(2, "debounce");
    eJoy1 = 6'b111110;         frames(1, "debounce");
    bus.joystick1 = 6'b111111; frames(2, "debounce");
    eJoy1 = 6'b111111;         frames(1, "debounce");

    $display("[TB] start and service");
    bus.start_button = 2'b01; bus.service = 1'b0; frames(2, "start_svc");
    eStart = 2'b01; eSvc = 1'b0;                   frames(1, "start_svc");
    bus.start_button = 2'b11; bus.service = 1'b1; frames(2, "start_svc");
    eStart = 2'b11; eSvc = 1'b1;                   frames(1, "start_svc");

    $display("[TB] SOCD joystick2");
    bus.joystick2 = 6'b010011; frames(2, "socd_ud");
    eJoy2 = 6'b011111;         frames(1, "socd_ud");
    bus.joystick2 = 6'b010111; frames(2, "socd_ud");
    eJoy2 = 6'b010111;         frames(1, "socd_ud");
    bus.joystick2 = 6'b111111; frames(2, "socd_ud");
    eJoy2 = 6'b111111;         frames(1, "socd_ud");
    bus.joystick2 = 6'b111100; frames(3, "socd_lr");
    bus.joystick2 = 6'b111111; frames(3, "socd_lr");

    $display("[TB] pause toggle");
    bus.pause_btn = 1'b0; frames(2, "pause");
    ePause = 1'b0;        frames(1, "pause");
    bus.pause_btn = 1'b1; frames(3, "pause");
    bus.pause_btn = 1'b0; frames(2, "pause");
    ePause = 1'b1;        frames(1, "pause");
    bus.pause_btn = 1'b1; frames(3, "pause");
    bus.pause_btn = 1'b0; frames(2, "pause_hold");
    ePause = 1'b0;        frames(8, "pause_hold");
    bus.pause_btn = 1'b1; frames(3, "pause_hold");

    $display("[TB] single held coin");
    bus.coin_input = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      eCoin[0] = !(i >= 4 && i <= 7);
      applyStimulus("coin_single");
    end
    bus.coin_input = 2'b11; eCoin = 2'b11;
    frames(12, "coin_single");

    $display("[TB] coin queue saturation");
    for (int t = 1; t <= 106; t++) begin
      bus.coin_input[1] = !(t <= 72 && ((t - 1) % 6) < 3);
      eCoin[1] = 1'b1;
      foreach (starts[k]) if (t >= starts[k] && t <= starts[k] + 3) eCoin[1] = 1'b0;
      applyStimulus("coin_queue");
    end
    bus.coin_input = 2'b11; eCoin = 2'b11;

    $display("[TB] mid-operation reset");
    bus.joystick1 = 6'b111110; bus.start_button = 2'b10;
    for (int t = 1; t <= 10; t++) begin
      bus.coin_input[0] = !(t <= 3 || t >= 7);
      eCoin[0] = !(t >= 4 && t <= 7);
      if (t >= 3) begin
        eJoy1 = 6'b111110;
        eStart = 2'b10;
      end
      applyStimulus("pre_reset");
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    setIdleExpect();
    checkOutput("reset_mid", actualVec(), expectVec());
    @(negedge clk);
    releaseInputs();
    @(negedge clk);
    rst = 1'b0;
    frames(15, "after_reset");

    repeat (20) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
